// File: rtl/cpu_core_if.sv
// Harvard memory bus between the RV32I core and its instruction/data memories.
// The core is the master: it drives both addresses and the store controls,
// and the memories answer combinationally in the same cycle.
interface cpu_core_if;
  logic [31:0] instruction;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [31:0] address_instruction;
  logic [31:0] address_data;
  logic        data_write;
  logic [3:0]  data_byte_en;

  modport master (
    input  instruction,
    input  data_in,
    output data_out,
    output address_instruction,
    output address_data,
    output data_write,
    output data_byte_en
  );

  modport slave (
    output instruction,
    output data_in,
    input  data_out,
    input  address_instruction,
    input  address_data,
    input  data_write,
    input  data_byte_en
  );
endinterface

// File: rtl/cpu_core.sv
// Single-cycle RV32I integer core. One instruction is fetched, decoded and
// executed per clock; register file and PC update on the rising edge. Loads
// and stores go straight to the data port in the same cycle (CPI = 1).
module cpu_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic        clk,
  input logic        rst,
  cpu_core_if.master bus
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0] pc;
  logic [31:0] regs [0:31];

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] pc_plus4, ea, next_pc, rd_val;
  logic        rd_we, is_store;

  // ALU shared by register-register and register-immediate ops; alt selects
  // SUB over ADD and arithmetic over logical right shift.
  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] f, input logic alt);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (f)
      3'd0:    alu = alt ? (a - b) : (a + b);
      3'd1:    alu = a << b[4:0];
      3'd2:    alu = {31'd0, (sa < sb)};
      3'd3:    alu = {31'd0, (a < b)};
      3'd4:    alu = a ^ b;
      3'd5:    alu = alt ? $unsigned(sa >>> b[4:0]) : (a >> b[4:0]);
      3'd6:    alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  // Branch condition; the two reserved funct3 codes never branch.
  function automatic logic branch_taken(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (f)
      3'd0:    branch_taken = (a == b);
      3'd1:    branch_taken = (a != b);
      3'd4:    branch_taken = (sa < sb);
      3'd5:    branch_taken = (sa >= sb);
      3'd6:    branch_taken = (a < b);
      3'd7:    branch_taken = (a >= b);
      default: branch_taken = 1'b0;
    endcase
  endfunction

  // Lane select: shift the addressed byte down to bit 0, zeros fill from the
  // top so a misaligned half/word never wraps into the next memory word.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0] lane,
                                               input logic [2:0] f);
    logic [31:0] s;
    s = word >> {lane, 3'b000};
    case (f)
      3'd0:    load_extract = {{24{s[7]}}, s[7:0]};
      3'd1:    load_extract = {{16{s[15]}}, s[15:0]};
      3'd2:    load_extract = s;
      3'd4:    load_extract = {24'd0, s[7:0]};
      3'd5:    load_extract = {16'd0, s[15:0]};
      default: load_extract = 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] store_mask(input logic [1:0] lane, input logic [2:0] f);
    case (f)
      3'd0:    store_mask = 4'b0001 << lane;
      3'd1:    store_mask = lane[1] ? 4'b1100 : 4'b0011;
      3'd2:    store_mask = 4'b1111;
      default: store_mask = 4'b0000;
    endcase
  endfunction

  assign instr  = bus.instruction;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
  assign pc_plus4 = pc + 32'd4;
  assign ea       = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign is_store = (opcode == OP_STORE) && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);

  assign bus.address_instruction = pc;
  assign bus.address_data        = ea;

  // Decode/execute: result, writeback enable and next PC for the current word.
  always_comb begin
    rd_val  = 32'd0;
    rd_we   = 1'b0;
    next_pc = pc_plus4;
    case (opcode)
      OP_LUI: begin
        rd_val = imm_u;
        rd_we  = 1'b1;
      end
      OP_AUIPC: begin
        rd_val = pc + imm_u;
        rd_we  = 1'b1;
      end
      OP_JAL: begin
        rd_val  = pc_plus4;
        rd_we   = 1'b1;
        next_pc = pc + imm_j;
      end
      OP_JALR: begin
        rd_val  = pc_plus4;
        rd_we   = 1'b1;
        next_pc = (rs1_val + imm_i) & ~32'd1;
      end
      OP_BRANCH: begin
        if (branch_taken(rs1_val, rs2_val, f3)) next_pc = pc + imm_b;
      end
      OP_LOAD: begin
        rd_val = load_extract(bus.data_in, ea[1:0], f3);
        rd_we  = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
      end
      OP_IMM: begin
        // Only SRAI uses bit 30 as a modifier; ADDI with bit 30 set is still ADD.
        rd_val = alu(rs1_val, imm_i, f3, (f3 == 3'd5) && instr[30]);
        rd_we  = 1'b1;
      end
      OP_REG: begin
        rd_val = alu(rs1_val, rs2_val, f3, instr[30]);
        rd_we  = 1'b1;
      end
      default: begin
        rd_we = 1'b0;
      end
    endcase
  end

  // Store lanes: replicate rs2 so memory picks bytes by byte enable alone.
  always_comb begin
    case (f3)
      3'd0:    bus.data_out = {4{rs2_val[7:0]}};
      3'd1:    bus.data_out = {2{rs2_val[15:0]}};
      default: bus.data_out = rs2_val;
    endcase
    // Held low during reset so an aborted store never reaches memory.
    bus.data_write   = is_store && !rst;
    bus.data_byte_en = (is_store && !rst) ? store_mask(ea[1:0], f3) : 4'b0000;
  end

  // Architectural state commit: PC and register file; x0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else begin
      pc <= next_pc;
      if (rd_we && (rd != 5'd0)) regs[rd] <= rd_val;
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: word-addressed instruction and data memories
// answer combinationally; results are observed on the data bus via stores.
module tb_cpu_core;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:63];

  localparam logic [31:0] NOP = 32'h0000_0013;

  cpu_core_if bus ();

  cpu_core #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    bus.instruction = imem[bus.address_instruction[7:2]];
    bus.data_in     = dmem[bus.address_data[7:2]];
  end

  always @(posedge clk) begin
    if (bus.data_write) begin
      for (int b = 0; b < 4; b++)
        if (bus.data_byte_en[b]) dmem[bus.address_data[7:2]][8*b +: 8] <= bus.data_out[8*b +: 8];
    end
  end

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    enc_i = {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    enc_s = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    enc_b = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    enc_j = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    enc_r = {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_pc(input logic [31:0] target);
    int n;
    n = 0;
    while (bus.address_instruction !== target && n < 64) begin
      step();
      n++;
    end
    chk("reach_pc", bus.address_instruction, target);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) begin
      imem[i] = NOP;
      dmem[i] = 32'd0;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    clear_mem();

    // ---------------- Program 1: ALU, loads, stores ----------------
    imem[0]  = 32'h0050_0093;                          // ADDI x1,x0,5
    imem[1]  = 32'h0010_8133;                          // ADD  x2,x1,x1
    imem[2]  = 32'h0020_2423;                          // SW   x2,8(x0)
    imem[3]  = 32'h1234_52B7;                          // LUI  x5,0x12345
    imem[4]  = enc_s(12'd12, 5'd5, 5'd0, 3'd2);        // SW   x5,12(x0)
    imem[5]  = enc_i(12'd1, 5'd0, 3'd0, 5'd3, 7'b0000011); // LB  x3,1(x0)
    imem[6]  = enc_s(12'd16, 5'd3, 5'd0, 3'd2);        // SW   x3,16(x0)
    imem[7]  = enc_i(12'd1, 5'd0, 3'd4, 5'd4, 7'b0000011); // LBU x4,1(x0)
    imem[8]  = enc_s(12'd20, 5'd4, 5'd0, 3'd2);        // SW   x4,20(x0)
    imem[9]  = enc_s(12'd2, 5'd1, 5'd0, 3'd0);         // SB   x1,2(x0)
    imem[10] = enc_s(12'd2, 5'd5, 5'd0, 3'd1);         // SH   x5,2(x0)
    imem[11] = 32'h0070_0013;                          // ADDI x0,x0,7
    imem[12] = enc_s(12'd24, 5'd0, 5'd0, 3'd2);        // SW   x0,24(x0)
    imem[13] = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd6);   // SUB  x6,x1,x2
    imem[14] = enc_i(12'h401, 5'd6, 3'd5, 5'd7, 7'b0010011); // SRAI x7,x6,1
    imem[15] = enc_s(12'd28, 5'd7, 5'd0, 3'd2);        // SW   x7,28(x0)
    imem[16] = enc_r(7'h00, 5'd1, 5'd6, 3'd2, 5'd8);   // SLT  x8,x6,x1
    imem[17] = enc_r(7'h00, 5'd1, 5'd6, 3'd3, 5'd9);   // SLTU x9,x6,x1
    imem[18] = enc_s(12'd32, 5'd8, 5'd0, 3'd2);        // SW   x8,32(x0)
    imem[19] = enc_s(12'd36, 5'd9, 5'd0, 3'd2);        // SW   x9,36(x0)
    imem[20] = enc_j(21'd0, 5'd0);                     // JAL  x0,0 (park)
    dmem[0]  = 32'h0000_8000;

    step();
    chk("rst_pc", bus.address_instruction, 32'h0);
    chk("rst_dw", {31'd0, bus.data_write}, 32'h0);
    #2 rst = 1'b0;
    #1;
    chk("start_pc", bus.address_instruction, 32'h0);

    goto_pc(32'h08);
    chk("sw_addr", bus.address_data, 32'd8);
    chk("sw_data", bus.data_out, 32'd10);
    chk("sw_we", {31'd0, bus.data_write}, 32'd1);
    chk("sw_be", {28'd0, bus.data_byte_en}, 32'hF);

    goto_pc(32'h10);
    chk("lui_data", bus.data_out, 32'h1234_5000);
    chk("mem_word2", dmem[2], 32'd10);

    goto_pc(32'h14);
    chk("lb_addr", bus.address_data, 32'd1);
    chk("lb_we", {31'd0, bus.data_write}, 32'd0);
    chk("lb_be", {28'd0, bus.data_byte_en}, 32'h0);

    goto_pc(32'h18);
    chk("lb_sext", bus.data_out, 32'hFFFF_FF80);
    goto_pc(32'h20);
    chk("lbu_zext", bus.data_out, 32'h0000_0080);

    goto_pc(32'h24);
    chk("sb_data", bus.data_out, 32'h0505_0505);
    chk("sb_be", {28'd0, bus.data_byte_en}, 32'h4);
    goto_pc(32'h28);
    chk("sh_data", bus.data_out, 32'h5000_5000);
    chk("sh_be", {28'd0, bus.data_byte_en}, 32'hC);

    goto_pc(32'h30);
    chk("x0_data", bus.data_out, 32'h0);
    chk("mem_lanes", dmem[0], 32'h5000_8000);

    goto_pc(32'h3C);
    chk("srai_data", bus.data_out, 32'hFFFF_FFFD);
    goto_pc(32'h48);
    chk("slt_data", bus.data_out, 32'd1);
    goto_pc(32'h4C);
    chk("sltu_data", bus.data_out, 32'd0);

    // ---------------- Program 2: control flow, wrap, reset ----------------
    rst = 1'b1;
    clear_mem();
    imem[0]  = enc_s(12'd0, 5'd0, 5'd0, 3'd2);         // SW   x0,0(x0)
    imem[1]  = enc_s(12'd44, 5'd3, 5'd0, 3'd2);        // SW   x3,44(x0)
    imem[4]  = enc_b(13'd8, 5'd0, 5'd0, 3'd0);         // 0x10 BEQ x0,x0,+8
    imem[6]  = enc_b(13'd8, 5'd0, 5'd0, 3'd1);         // 0x18 BNE x0,x0,+8
    imem[8]  = enc_j(21'd16, 5'd1);                    // 0x20 JAL x1,+16
    imem[12] = enc_s(12'd40, 5'd1, 5'd0, 3'd2);        // 0x30 SW x1,40(x0)
    imem[13] = enc_i(12'hFFF, 5'd0, 3'd0, 5'd2, 7'b0010011); // 0x34 ADDI x2,x0,-1
    imem[14] = enc_b(13'd8, 5'd0, 5'd2, 3'd4);         // 0x38 BLT x2,x0,+8
    imem[16] = enc_b(13'd8, 5'd0, 5'd2, 3'd6);         // 0x40 BLTU x2,x0,+8
    imem[17] = enc_b(13'd12, 5'd0, 5'd2, 3'd7);        // 0x44 BGEU x2,x0,+12
    imem[20] = enc_i(12'hFFD, 5'd0, 3'd0, 5'd3, 7'b1100111); // 0x50 JALR x3,-3(x0)

    step();
    chk("rst2_pc", bus.address_instruction, 32'h0);
    chk("rst2_dw", {31'd0, bus.data_write}, 32'h0);
    chk("rst2_be", {28'd0, bus.data_byte_en}, 32'h0);
    #2 rst = 1'b0;
    #1;
    chk("run_dw", {31'd0, bus.data_write}, 32'h1);
    step();
    chk("x3_zero", bus.data_out, 32'h0);

    goto_pc(32'h10);
    step();
    chk("beq_pc", bus.address_instruction, 32'h18);
    step();
    chk("bne_pc", bus.address_instruction, 32'h1C);
    step();
    step();
    chk("jal_pc", bus.address_instruction, 32'h30);
    chk("jal_link", bus.data_out, 32'h24);
    step();
    step();
    step();
    chk("blt_pc", bus.address_instruction, 32'h40);
    step();
    chk("bltu_pc", bus.address_instruction, 32'h44);
    step();
    chk("bgeu_pc", bus.address_instruction, 32'h50);
    step();
    chk("jalr_pc", bus.address_instruction, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc", bus.address_instruction, 32'h0);
    step();
    chk("jalr_link", bus.data_out, 32'h54);

    #3 rst = 1'b1;
    #1;
    chk("async_pc", bus.address_instruction, 32'h0);
    chk("async_dw", {31'd0, bus.data_write}, 32'h0);
    #2 rst = 1'b0;
    step();
    chk("rst_clr_pc", bus.address_instruction, 32'h4);
    chk("rst_clr_x3", bus.data_out, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
